instr_cache_sa: RTL and testbench
=================================

# instr_cache_sa

Parametrised set-associative instruction cache with its own refill controller. It sits between the fetch stage and the memory/bus interface. A hit returns the instruction combinationally in the same cycle. A miss stalls fetch, requests the block-aligned line over a valid/ack handshake, and allocates it into a victim way chosen by valid-first then per-set round-robin. Instruction invalidation (fence.i) clears all lines in one cycle.

## Interface
- WAYS, 2: associativity; power of 2, ≥1.
- SET_COUNT, 4: number of sets; power of 2, ≥2.
- WORD_SIZE, 32: instruction word width.
- BLOCK_WIDTH, 512: line width; multiple of WORD_SIZE.
- ADDR_WIDTH, 32: fetch address width.
- clk  in  1  clock.
- arst  in  1  reset, asynchronous, active-high.
- i_req  in  1  fetch request valid.
- i_instr_addr  in  ADDR_WIDTH  fetch address; held stable by core while o_stall=1.
- i_invalidate_instr  in  1  clear all valid bits.
- o_instr  out  WORD_SIZE  selected word on hit, else 0.
- o_hit  out  1  lookup hit this cycle.
- o_stall  out  1  fetch must hold.
- o_instr_addr_ma  out  1  |i_instr_addr[1:0].
- o_mem_req  out  1  refill request, held until i_mem_valid.
- o_mem_addr  out  ADDR_WIDTH  latched miss address with offset bits zeroed.
- i_mem_valid  in  1  refill data valid; acknowledges o_mem_req.
- i_mem_data  in  BLOCK_WIDTH  refill line.

## Operation
- Address split, LSB first: byte offset log2(WORD_SIZE/8), word offset log2(BLOCK_WIDTH/WORD_SIZE), index log2(SET_COUNT), tag = remainder.
- Storage per way, per set: tag, line, valid. Per set: round-robin victim pointer, log2(WAYS) bits.
- Only valid bits, victim pointers, FSM state and the latched miss address are reset. Tag and data arrays are not reset.
- Lookup: compare all ways of the indexed set in parallel.
  - o_hit = i_req & ~ma & IDLE & any valid tag match.
  - Matching is one-hot by construction. o_instr is muxed from the matching way, else 0.
- FSM IDLE:
  - i_req & ~ma & ~hit & ~i_invalidate_instr → latch address, go to REFILL.
  - A misaligned request never refills. o_hit=0, o_stall=0; the trap is raised downstream.
- FSM REFILL:
  - o_mem_req=1, o_mem_addr = latched block address.
  - On i_mem_valid: write tag and line into the victim way, set valid, go to IDLE.
  - Victim = lowest-index invalid way in the set. If none is invalid, victim = set pointer, and the pointer increments modulo WAYS.
  - The pointer is unchanged when an invalid way was used.
- o_stall = REFILL | (i_req & ~ma & ~hit).
- Invalidate, in any state: all valid bits ← 0 next edge.
  - In REFILL with i_mem_valid in the same cycle: line and tag are written but valid stays 0; FSM → IDLE.
  - In REFILL without i_mem_valid: FSM stays; the eventual fill is marked valid.
  - Invalidate has priority over the fill's valid set.
- arst mid-REFILL: FSM → IDLE, o_mem_req → 0 asynchronously. A late i_mem_valid while in IDLE is ignored.

## Timing
- Reset values:
  - o_mem_req=0, o_mem_addr=0, state IDLE, all valid=0, pointers=0.
  - o_hit=0 and o_instr=0 (no valid lines).
  - o_stall = i_req & ~ma; o_instr_addr_ma is combinational.
- Hit latency: 0 cycles (combinational).
- Miss:
  - Cycle 0: miss seen.
  - Cycle 1: o_mem_req=1.
  - Cycle k: i_mem_valid.
  - Cycle k+1: IDLE, hit on the same address.
  - Minimum miss penalty is 2 cycles, with i_mem_valid on cycle 1.
- o_mem_req and o_mem_addr are registered-state driven and glitch-free.

## Structure
- Package instr_cache_pkg holds:
  - state enum {IDLE, REFILL};
  - derived-width localparam functions (offset, index, tag widths).
- Sub-module instr_cache_way: one way's tag, data and valid arrays.
  - Outputs: match and selected word for a given index, tag and word offset.
  - Inputs: write port, plus a global valid-clear port.
- The top instantiates WAYS ways via generate, and holds the FSM, victim selection, pointers and output mux.

## Test plan
Configuration for all scenarios: WAYS=2, SET_COUNT=4, BLOCK_WIDTH=512, so index = addr[7:6] and tag = addr[31:8].
- Cold miss:
  - Stimulus: after arst, i_req with addr 0x0000_0104.
  - Response: o_hit=0, o_stall=1; next cycle o_mem_req=1 with o_mem_addr=0x0000_0100.
  - Return a line whose word n = 0xA000_0000+n: the next cycle gives o_hit=1, o_instr=0xA000_0001.
- Same-line hit: addr 0x0000_013C → o_hit=1, o_instr=0xA000_000F in the same cycle, no o_mem_req.
- Replacement:
  - Fill 0x100, then 0x200 (both set 0): both land in way 0 then way 1 via the invalid-first rule.
  - Fill 0x300: evicts way 0 (pointer 0→1).
  - Afterwards 0x100 misses, while 0x200 and 0x300 hit.
- Misaligned fetch: addr 0x0000_0102 → o_instr_addr_ma=1, o_hit=0, o_stall=0, no o_mem_req.
- Invalidate:
  - Coincident with i_mem_valid on a fill of 0x400: FSM → IDLE, and the re-fetch of 0x400 misses.
  - Standalone invalidate: all prior hits become misses.
- Reset mid-refill: arst asserted while o_mem_req=1 → o_mem_req=0 immediately; a following i_mem_valid pulse causes no fill, and 0x100 still misses.

Source files
------------

// File: rtl/instr_cache_pkg.sv
// Shared types and address-field width helpers for the set-associative instruction cache.
package instr_cache_pkg;

    typedef enum logic {
        IDLE   = 1'b0,
        REFILL = 1'b1
    } state_e;

    function automatic int byte_off_w(input int word_size);
        return $clog2(word_size / 8);
    endfunction

    function automatic int word_off_w(input int block_width, input int word_size);
        return $clog2(block_width / word_size);
    endfunction

    function automatic int offset_w(input int block_width);
        return $clog2(block_width / 8);
    endfunction

    function automatic int index_w(input int set_count);
        return $clog2(set_count);
    endfunction

    function automatic int tag_w(input int addr_width, input int set_count, input int block_width);
        return addr_width - offset_w(block_width) - index_w(set_count);
    endfunction

    // A direct-mapped cache still carries a 1-bit pointer that is held at zero.
    function automatic int ptr_w(input int ways);
        return (ways > 1) ? $clog2(ways) : 1;
    endfunction

endpackage

// File: rtl/instr_cache_way.sv
// One cache way: tag/line arrays (unreset) plus per-set valid bits with a global clear.
// Lookup is combinational; a clear on the same edge as a write wins over the write's valid set.
module instr_cache_way #(
    parameter int SET_COUNT   = 4,
    parameter int IDX_W       = 2,
    parameter int TAG_W       = 24,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WIDTH = 512,
    parameter int WOFF_W      = 4
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic [IDX_W-1:0]       rd_idx_i,
    input  logic [TAG_W-1:0]       rd_tag_i,
    input  logic [WOFF_W-1:0]      rd_woff_i,
    output logic                   match_o,
    output logic [WORD_SIZE-1:0]   word_o,
    output logic [SET_COUNT-1:0]   valid_o,
    input  logic                   wr_en_i,
    input  logic [IDX_W-1:0]       wr_idx_i,
    input  logic [TAG_W-1:0]       wr_tag_i,
    input  logic [BLOCK_WIDTH-1:0] wr_line_i,
    input  logic                   clr_i
);

    logic [TAG_W-1:0]       tag_q  [SET_COUNT];
    logic [BLOCK_WIDTH-1:0] line_q [SET_COUNT];
    logic [SET_COUNT-1:0]   valid_q;
    logic [SET_COUNT-1:0]   valid_d;

    always_ff @(posedge clk) begin
        if (wr_en_i) begin
            tag_q[wr_idx_i]  <= wr_tag_i;
            line_q[wr_idx_i] <= wr_line_i;
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (wr_en_i) valid_d[wr_idx_i] = 1'b1;
        if (clr_i)   valid_d = '0;
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) valid_q <= '0;
        else      valid_q <= valid_d;
    end

    assign match_o = valid_q[rd_idx_i] && (tag_q[rd_idx_i] == rd_tag_i);
    assign word_o  = match_o ? line_q[rd_idx_i][rd_woff_i*WORD_SIZE +: WORD_SIZE] : '0;
    assign valid_o = valid_q;

endmodule

// File: rtl/instr_cache_sa.sv
// Set-associative instruction cache with refill FSM; hits return in the same cycle.
// Misses stall fetch and hold o_mem_req until i_mem_valid; victim is first invalid way, else per-set round-robin.
module instr_cache_sa
    import instr_cache_pkg::*;
#(
    parameter int WAYS        = 2,
    parameter int SET_COUNT   = 4,
    parameter int WORD_SIZE   = 32,
    parameter int BLOCK_WIDTH = 512,
    parameter int ADDR_WIDTH  = 32
) (
    input  logic                   clk,
    input  logic                   arst,
    input  logic                   i_req,
    input  logic [ADDR_WIDTH-1:0]  i_instr_addr,
    input  logic                   i_invalidate_instr,
    output logic [WORD_SIZE-1:0]   o_instr,
    output logic                   o_hit,
    output logic                   o_stall,
    output logic                   o_instr_addr_ma,
    output logic                   o_mem_req,
    output logic [ADDR_WIDTH-1:0]  o_mem_addr,
    input  logic                   i_mem_valid,
    input  logic [BLOCK_WIDTH-1:0] i_mem_data
);

    localparam int WORDS    = BLOCK_WIDTH / WORD_SIZE;
    localparam int BYTE_W   = byte_off_w(WORD_SIZE);
    localparam int WOFF_RAW = word_off_w(BLOCK_WIDTH, WORD_SIZE);
    localparam int WOFF_W   = (WOFF_RAW > 0) ? WOFF_RAW : 1;
    localparam int OFF_W    = offset_w(BLOCK_WIDTH);
    localparam int IDX_W    = index_w(SET_COUNT);
    localparam int TAG_W    = tag_w(ADDR_WIDTH, SET_COUNT, BLOCK_WIDTH);
    localparam int PTR_W    = ptr_w(WAYS);
    localparam logic [ADDR_WIDTH-1:0] BLK_MASK = ~((ADDR_WIDTH'(1) << OFF_W) - ADDR_WIDTH'(1));

    state_e                  state_q, state_d;
    logic [ADDR_WIDTH-1:0]   miss_addr_q, miss_addr_d;
    logic [PTR_W-1:0]        ptr_q [SET_COUNT];

    logic [IDX_W-1:0]        rd_idx, fill_idx;
    logic [TAG_W-1:0]        rd_tag, fill_tag;
    logic [WOFF_W-1:0]       rd_woff;
    logic [WAYS-1:0]         way_match, way_wr, set_valid;
    logic [WORD_SIZE-1:0]    way_word  [WAYS];
    logic [SET_COUNT-1:0]    way_valid [WAYS];
    logic [WORD_SIZE-1:0]    word_or;
    logic [PTR_W-1:0]        victim, ptr_next;
    logic                    found_invalid, fill, lookup_en;

    assign rd_idx   = IDX_W'(i_instr_addr >> OFF_W);
    assign rd_tag   = TAG_W'(i_instr_addr >> (OFF_W + IDX_W));
    assign rd_woff  = WOFF_W'((i_instr_addr >> BYTE_W) & ADDR_WIDTH'(WORDS - 1));
    assign fill_idx = IDX_W'(miss_addr_q >> OFF_W);
    assign fill_tag = TAG_W'(miss_addr_q >> (OFF_W + IDX_W));

    for (genvar w = 0; w < WAYS; w++) begin : g_way
        assign way_wr[w] = fill && (victim == PTR_W'(w));
        instr_cache_way #(
            .SET_COUNT  (SET_COUNT),
            .IDX_W      (IDX_W),
            .TAG_W      (TAG_W),
            .WORD_SIZE  (WORD_SIZE),
            .BLOCK_WIDTH(BLOCK_WIDTH),
            .WOFF_W     (WOFF_W)
        ) u_way (
            .clk      (clk),
            .arst     (arst),
            .rd_idx_i (rd_idx),
            .rd_tag_i (rd_tag),
            .rd_woff_i(rd_woff),
            .match_o  (way_match[w]),
            .word_o   (way_word[w]),
            .valid_o  (way_valid[w]),
            .wr_en_i  (way_wr[w]),
            .wr_idx_i (fill_idx),
            .wr_tag_i (fill_tag),
            .wr_line_i(i_mem_data),
            .clr_i    (i_invalidate_instr)
        );
    end

    assign o_instr_addr_ma = |i_instr_addr[1:0];
    assign lookup_en       = i_req && !o_instr_addr_ma && (state_q == IDLE);
    assign o_hit           = lookup_en && (|way_match);
    assign o_stall         = (state_q == REFILL) || (i_req && !o_instr_addr_ma && !o_hit);
    assign o_mem_addr      = miss_addr_q;

    // Way words are already zero unless matching, so OR-ing the one-hot results is the mux.
    always_comb begin
        word_or = '0;
        for (int w = 0; w < WAYS; w++) word_or = word_or | way_word[w];
    end
    assign o_instr = o_hit ? word_or : '0;

    always_comb begin
        set_valid     = '0;
        victim        = ptr_q[fill_idx];
        found_invalid = 1'b0;
        for (int w = 0; w < WAYS; w++) set_valid[w] = way_valid[w][fill_idx];
        for (int w = WAYS - 1; w >= 0; w--) begin
            if (!set_valid[w]) begin
                victim        = PTR_W'(w);
                found_invalid = 1'b1;
            end
        end
    end

    assign ptr_next = (ptr_q[fill_idx] == PTR_W'(WAYS - 1)) ? '0 : ptr_q[fill_idx] + PTR_W'(1);

    always_comb begin
        state_d     = state_q;
        miss_addr_d = miss_addr_q;
        fill        = 1'b0;
        o_mem_req   = 1'b0;
        case (state_q)
            IDLE: begin
                if (lookup_en && !(|way_match) && !i_invalidate_instr) begin
                    state_d     = REFILL;
                    miss_addr_d = i_instr_addr & BLK_MASK;
                end
            end
            REFILL: begin
                o_mem_req = 1'b1;
                if (i_mem_valid) begin
                    fill    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            state_q     <= IDLE;
            miss_addr_q <= '0;
        end else begin
            state_q     <= state_d;
            miss_addr_q <= miss_addr_d;
        end
    end

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            for (int s = 0; s < SET_COUNT; s++) ptr_q[s] <= '0;
        end else if (fill && !found_invalid) begin
            ptr_q[fill_idx] <= ptr_next;
        end
    end

endmodule

// File: tb/tb_instr_cache_sa.sv
// Self-checking bench: directed scenarios plus random fetches against a behavioural cache model.
module tb_instr_cache_sa;

    logic         clk;
    logic         arst;
    logic         i_req;
    logic [31:0]  i_instr_addr;
    logic         i_invalidate_instr;
    logic [31:0]  o_instr;
    logic         o_hit;
    logic         o_stall;
    logic         o_instr_addr_ma;
    logic         o_mem_req;
    logic [31:0]  o_mem_addr;
    logic         i_mem_valid;
    logic [511:0] i_mem_data;

    int checks   = 0;
    int failures = 0;

    // Model: per set, two slots holding tag, valid and the line's word-0 value (word n = base + n).
    bit          m_valid [4][2];
    logic [23:0] m_tag   [4][2];
    logic [31:0] m_base  [4][2];
    int          m_ptr   [4];

    instr_cache_sa dut (
        .clk               (clk),
        .arst              (arst),
        .i_req             (i_req),
        .i_instr_addr      (i_instr_addr),
        .i_invalidate_instr(i_invalidate_instr),
        .o_instr           (o_instr),
        .o_hit             (o_hit),
        .o_stall           (o_stall),
        .o_instr_addr_ma   (o_instr_addr_ma),
        .o_mem_req         (o_mem_req),
        .o_mem_addr        (o_mem_addr),
        .i_mem_valid       (i_mem_valid),
        .i_mem_data        (i_mem_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic bit m_hit(input logic [31:0] a);
        bit h = 1'b0;
        if (a[1:0] != 2'b00) return 1'b0;
        for (int w = 0; w < 2; w++)
            if (m_valid[a[7:6]][w] && m_tag[a[7:6]][w] == a[31:8]) h = 1'b1;
        return h;
    endfunction

    function automatic logic [31:0] m_instr(input logic [31:0] a);
        logic [31:0] r = '0;
        if (a[1:0] != 2'b00) return '0;
        for (int w = 0; w < 2; w++)
            if (m_valid[a[7:6]][w] && m_tag[a[7:6]][w] == a[31:8])
                r = m_base[a[7:6]][w] + 32'(a[5:2]);
        return r;
    endfunction

    task automatic m_fill(input logic [31:0] a, input logic [31:0] base, input bit setv);
        int s = int'(a[7:6]);
        int v = -1;
        for (int w = 0; w < 2; w++) if (!m_valid[s][w] && v < 0) v = w;
        if (v < 0) begin
            v        = m_ptr[s];
            m_ptr[s] = (m_ptr[s] + 1) % 2;
        end
        m_tag[s][v]   = a[31:8];
        m_base[s][v]  = base;
        m_valid[s][v] = setv;
    endtask

    task automatic m_inv();
        for (int s = 0; s < 4; s++) for (int w = 0; w < 2; w++) m_valid[s][w] = 1'b0;
    endtask

    task automatic m_reset();
        m_inv();
        for (int s = 0; s < 4; s++) m_ptr[s] = 0;
    endtask

    // Applies one cycle of inputs on the falling edge; callers sample 1 time unit later.
    task automatic step(input bit req, input logic [31:0] addr, input bit inv, input bit mv,
                        input logic [31:0] base);
        @(negedge clk);
        i_req              = req;
        i_instr_addr       = addr;
        i_invalidate_instr = inv;
        i_mem_valid        = mv;
        for (int n = 0; n < 16; n++) i_mem_data[n*32 +: 32] = base + n;
        #1;
    endtask

    // Completes an outstanding refill: nwait idle REFILL cycles, then the data beat.
    task automatic finish_refill(input logic [31:0] addr, input logic [31:0] base, input bit inv,
                                 input int nwait);
        for (int i = 0; i < nwait; i++) step(1'b1, addr, 1'b0, 1'b0, 32'h0);
        step(1'b1, addr, inv, 1'b1, base);
        m_fill(addr, base, !inv);
        if (inv) m_inv();
    endtask

    task automatic test_reset();
        @(negedge clk);
        #1;
        checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL reset_mem_req: got %b want 0", o_mem_req); end
        checks++; if (o_mem_addr !== 32'h0) begin failures++; $display("FAIL reset_mem_addr: got %h want 0", o_mem_addr); end
        checks++; if (o_hit !== 1'b0 || o_instr !== 32'h0) begin failures++; $display("FAIL reset_hit_instr: got %b/%h want 0/0", o_hit, o_instr); end
        checks++; if (o_stall !== 1'b0) begin failures++; $display("FAIL reset_stall_idle: got %b want 0", o_stall); end
        i_req = 1'b1; i_instr_addr = 32'h104; #1;
        checks++; if (o_stall !== 1'b1 || o_hit !== 1'b0) begin failures++; $display("FAIL reset_stall_req: got stall %b hit %b want 1/0", o_stall, o_hit); end
        i_instr_addr = 32'h106; #1;
        checks++; if (o_stall !== 1'b0 || o_instr_addr_ma !== 1'b1) begin failures++; $display("FAIL reset_ma: got stall %b ma %b want 0/1", o_stall, o_instr_addr_ma); end
        @(negedge clk);
        arst = 1'b0; i_req = 1'b0;
        m_reset();
    endtask

    task automatic test_cold_miss();
        step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0 || o_stall !== 1'b1 || o_mem_req !== 1'b0) begin failures++; $display("FAIL cold_c0: got hit %b stall %b req %b want 0/1/0", o_hit, o_stall, o_mem_req); end
        step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL cold_req: got %b want 1", o_mem_req); end
        checks++; if (o_mem_addr !== 32'h100) begin failures++; $display("FAIL cold_addr: got %h want 00000100", o_mem_addr); end
        finish_refill(32'h104, 32'hA000_0000, 1'b0, 0);
        step(1'b1, 32'h104, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hA000_0001) begin failures++; $display("FAIL cold_hit: got %b/%h want 1/a0000001", o_hit, o_instr); end
        checks++; if (o_stall !== 1'b0 || o_mem_req !== 1'b0) begin failures++; $display("FAIL cold_idle: got stall %b req %b want 0/0", o_stall, o_mem_req); end
    endtask

    task automatic test_same_line_hit();
        step(1'b1, 32'h13C, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hA000_000F) begin failures++; $display("FAIL line_hit: got %b/%h want 1/a000000f", o_hit, o_instr); end
        step(1'b1, 32'h13C, 1'b0, 1'b0, 32'h0);
        checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL line_noreq: got req %b stall %b want 0/0", o_mem_req, o_stall); end
    endtask

    task automatic test_replacement();
        step(1'b1, 32'h200, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0) begin failures++; $display("FAIL repl_200_miss: got %b want 0", o_hit); end
        finish_refill(32'h200, 32'hB000_0000, 1'b0, 1);
        step(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        finish_refill(32'h300, 32'hC000_0000, 1'b0, 1);
        step(1'b1, 32'h208, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hB000_0002) begin failures++; $display("FAIL repl_200_hit: got %b/%h want 1/b0000002", o_hit, o_instr); end
        step(1'b1, 32'h30C, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hC000_0003) begin failures++; $display("FAIL repl_300_hit: got %b/%h want 1/c0000003", o_hit, o_instr); end
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0 || o_stall !== 1'b1) begin failures++; $display("FAIL repl_100_evicted: got hit %b stall %b want 0/1", o_hit, o_stall); end
        finish_refill(32'h100, 32'hA000_0000, 1'b0, 2);
        step(1'b1, 32'h300, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hC000_0000) begin failures++; $display("FAIL repl_300_kept: got %b/%h want 1/c0000000", o_hit, o_instr); end
    endtask

    task automatic test_misaligned();
        step(1'b1, 32'h102, 1'b0, 1'b0, 32'h0);
        checks++; if (o_instr_addr_ma !== 1'b1 || o_hit !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL ma_outputs: got ma %b hit %b stall %b want 1/0/0", o_instr_addr_ma, o_hit, o_stall); end
        step(1'b1, 32'h403, 1'b0, 1'b0, 32'h0);
        checks++; if (o_mem_req !== 1'b0 || o_stall !== 1'b0) begin failures++; $display("FAIL ma_norefill: got req %b stall %b want 0/0", o_mem_req, o_stall); end
    endtask

    task automatic test_invalidate();
        step(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        finish_refill(32'h400, 32'hD000_0000, 1'b1, 0);
        step(1'b1, 32'h400, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0 || o_stall !== 1'b1 || o_mem_req !== 1'b0) begin failures++; $display("FAIL inv_fill_miss: got hit %b stall %b req %b want 0/1/0", o_hit, o_stall, o_mem_req); end
        finish_refill(32'h400, 32'hD000_0000, 1'b0, 0);
        step(1'b1, 32'h404, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hD000_0001) begin failures++; $display("FAIL inv_refetch: got %b/%h want 1/d0000001", o_hit, o_instr); end
        step(1'b1, 32'h500, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h500, 1'b1, 1'b0, 32'h0);
        m_inv();
        checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL inv_refill_hold: got req %b want 1", o_mem_req); end
        finish_refill(32'h500, 32'hE000_0000, 1'b0, 0);
        step(1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1 || o_instr !== 32'hE000_0001) begin failures++; $display("FAIL inv_late_fill: got %b/%h want 1/e0000001", o_hit, o_instr); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        m_inv();
        step(1'b1, 32'h504, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0 || o_stall !== 1'b1) begin failures++; $display("FAIL inv_all_500: got hit %b stall %b want 0/1", o_hit, o_stall); end
        finish_refill(32'h504, 32'hE000_0000, 1'b0, 0);
        step(1'b1, 32'h13C, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0) begin failures++; $display("FAIL inv_all_100: got hit %b want 0", o_hit); end
        finish_refill(32'h13C, 32'hA000_0000, 1'b0, 0);
    endtask

    task automatic test_reset_mid_refill();
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b1) begin failures++; $display("FAIL rst_pre_hit: got %b want 1", o_hit); end
        step(1'b0, 32'h0, 1'b1, 1'b0, 32'h0);
        m_inv();
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_mem_req !== 1'b1) begin failures++; $display("FAIL rst_req_up: got %b want 1", o_mem_req); end
        @(negedge clk);
        arst = 1'b1;
        #1;
        m_reset();
        checks++; if (o_mem_req !== 1'b0 || o_mem_addr !== 32'h0) begin failures++; $display("FAIL rst_async: got req %b addr %h want 0/0", o_mem_req, o_mem_addr); end
        @(negedge clk);
        arst = 1'b0;
        i_req = 1'b0;
        step(1'b0, 32'h100, 1'b0, 1'b1, 32'hF000_0000);
        checks++; if (o_mem_req !== 1'b0) begin failures++; $display("FAIL rst_late_valid: got req %b want 0", o_mem_req); end
        step(1'b1, 32'h100, 1'b0, 1'b0, 32'h0);
        checks++; if (o_hit !== 1'b0 || o_stall !== 1'b1) begin failures++; $display("FAIL rst_no_fill: got hit %b stall %b want 0/1", o_hit, o_stall); end
        finish_refill(32'h100, 32'hA000_0000, 1'b0, 0);
    endtask

    task automatic test_random();
        logic [31:0] addr;
        bit          inv, exp_hit, exp_ma;
        logic [31:0] exp_instr;
        int          nw;
        repeat (300) begin
            addr = {24'($urandom_range(1, 6)), 2'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 2'b00};
            if ($urandom_range(0, 9) == 0) addr[1:0] = 2'($urandom_range(1, 3));
            inv       = ($urandom_range(0, 15) == 0);
            exp_hit   = m_hit(addr);
            exp_instr = m_instr(addr);
            exp_ma    = (addr[1:0] != 2'b00);
            step(1'b1, addr, inv, 1'b0, 32'h0);
            checks++; if (o_hit !== exp_hit || o_instr !== exp_instr) begin failures++; $display("FAIL rnd_lookup @%h: got %b/%h want %b/%h", addr, o_hit, o_instr, exp_hit, exp_instr); end
            checks++; if (o_stall !== (!exp_ma && !exp_hit) || o_instr_addr_ma !== exp_ma) begin failures++; $display("FAIL rnd_stall_ma @%h: got %b/%b want %b/%b", addr, o_stall, o_instr_addr_ma, !exp_ma && !exp_hit, exp_ma); end
            if (inv) m_inv();
            if (!exp_ma && !exp_hit && !inv) begin
                nw = $urandom_range(0, 3);
                if (nw == 0) begin
                    finish_refill(addr, $urandom, ($urandom_range(0, 7) == 0), 0);
                end else begin
                    step(1'b1, addr, 1'b0, 1'b0, 32'h0);
                    checks++; if (o_mem_req !== 1'b1 || o_mem_addr !== {addr[31:6], 6'b0}) begin failures++; $display("FAIL rnd_req @%h: got %b/%h want 1/%h", addr, o_mem_req, o_mem_addr, {addr[31:6], 6'b0}); end
                    finish_refill(addr, $urandom, ($urandom_range(0, 7) == 0), nw - 1);
                end
            end
        end
    endtask

    initial begin
        arst               = 1'b1;
        i_req              = 1'b0;
        i_instr_addr       = '0;
        i_invalidate_instr = 1'b0;
        i_mem_valid        = 1'b0;
        i_mem_data         = '0;
        m_reset();
        test_reset();
        test_cold_miss();
        test_same_line_hit();
        test_replacement();
        test_misaligned();
        test_invalidate();
        test_reset_mid_refill();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
